vm_credit_controller: RTL and testbench
=======================================

// Module: vm_credit_controller
// PURPOSE
//  Transaction front end of the vending machine, directly upstream of the change maker.
//  - Accepts coin pulses into a credit register.
//  - Keeps per-denomination coin inventory and drives the change maker's flag_* inputs.
//  - Computes change on vend or cancel, launches the change maker with a one-cycle flag_once.
//  - Tracks the dispense until the change maker's local_change reaches 0.
// PARAMETERS
//  WIDTH       12    width of credit, price and change in cents
//  MAX_CREDIT  1000  maximum credit; a coin that would exceed it is rejected
//  INV_W       8     width of each coin inventory counter
//  INIT_INV    10    reset value of every inventory counter
//  STALL_CYC   16    cycles allowed with no change_* pulse while dispensing, then abort
// PORTS
//  clk                 in   1      rising-edge clock
//  reset               in   1      asynchronous, active-low reset
//  coin_dollar         in   1      one-cycle pulse: 100c coin inserted
//  coin_half_dollar    in   1      one-cycle pulse: 50c inserted
//  coin_quarter        in   1      one-cycle pulse: 25c inserted
//  coin_dime           in   1      one-cycle pulse: 10c inserted
//  coin_nickel         in   1      one-cycle pulse: 5c inserted
//  item_price          in   WIDTH  price of selected item, sampled with item_select
//  item_select         in   1      one-cycle pulse: purchase request
//  cancel              in   1      one-cycle pulse: refund all credit
//  change_dollar       in   1      from change maker: 100c dispensed (same for next four)
//  change_half_dollar  in   1      from change maker: 50c dispensed
//  change_quarter      in   1      from change maker: 25c dispensed
//  change_dime         in   1      from change maker: 10c dispensed
//  change_nickel       in   1      from change maker: 5c dispensed
//  local_change        in   WIDTH  from change maker: change still owed
//  change              out  WIDTH  change amount to change maker; held stable until IDLE
//  flag_once           out  1      one-cycle load strobe to change maker
//  flag_dollar         out  1      dollar inventory nonzero (same for next four)
//  flag_half_dollar    out  1      half-dollar inventory nonzero
//  flag_quarter        out  1      quarter inventory nonzero
//  flag_dime           out  1      dime inventory nonzero
//  flag_nickel         out  1      nickel inventory nonzero
//  credit              out  WIDTH  current accumulated credit
//  vend                out  1      one-cycle pulse: release item
//  busy                out  1      high in START, DISPENSE and DONE
//  coin_reject         out  1      one-cycle pulse, 1 cycle after a rejected coin
//  change_short        out  1      one-cycle pulse: dispense aborted on stall
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; credit=0; change=0; all inventory counters=INIT_INV.
//   All pulse outputs and busy are 0. flag_* = (INIT_INV!=0).
//  States: IDLE -> CREDIT -> START -> DISPENSE -> DONE -> IDLE.
//  Coin acceptance (IDLE/CREDIT only), registered, visible next cycle:
//  - A coin is rejected if any of these hold:
//    - more than one coin_* is high in the cycle;
//    - credit+value > MAX_CREDIT;
//    - that denomination's counter is saturated (2^INV_W-1);
//    - item_select or cancel is high in the same cycle;
//    - the FSM is busy.
//  - A rejected coin leaves credit and inventory unchanged and pulses coin_reject.
//  - An accepted coin adds its value to credit and increments its counter. IDLE goes to CREDIT.
//  CREDIT:
//  - cancel (wins over item_select): change<=credit; go START; no vend.
//  - item_select with credit>=item_price: change<=credit-item_price; vend pulses; go START.
//  - item_select with credit<item_price: ignored, stay in CREDIT.
//  - In IDLE, item_select and cancel are ignored.
//  START (1 cycle): credit<=0.
//  - change!=0: flag_once=1 this cycle, then go DISPENSE.
//  - change==0: no flag_once; go DONE.
//  DISPENSE:
//  - Every change_x pulse decrements counter x, floored at 0. flag_x = (counter_x!=0) from the register.
//  - The first DISPENSE cycle is a guard: local_change is not checked.
//  - After the guard, local_change==0 with no change_* pulse: go DONE.
//  - Stall counter clears on any change_* pulse.
//  - STALL_CYC cycles with no pulse and local_change!=0: change_short pulses, go DONE.
//  DONE (1 cycle): change<=0; go IDLE. busy falls on entry to IDLE.
//  Reset at any point, including mid-dispense, aborts the transaction to the reset values.
//  Arithmetic is unsigned WIDTH bits. Overflow cannot occur because MAX_CREDIT < 2^WIDTH.
// TESTING
//  1. Dime, quarter, dollar; item_select price=110 -> credit 135; vend; change=25; flag_once 1 cycle; one change_quarter; IDLE.
//  2. Two quarters; cancel -> no vend; change=50; flag_once; one change_half_dollar; quarter inventory 12, half-dollar 9.
//  3. credit=980, insert quarter -> coin_reject; credit stays 980. coin_dime and coin_nickel in same cycle -> both rejected.
//  4. Nickel counter at 1 and change=10 with dime inventory 0 -> flag_nickel falls after 1st nickel; no pulses for 16 cycles -> change_short, IDLE.
//  5. item_select and cancel in same cycle with credit=75, price=50 -> cancel wins; change=75; no vend.
//  6. reset low mid-DISPENSE -> outputs and inventory back to reset values asynchronously; coin accepted after release.

Source files
------------

// File: rtl/vm_credit_controller.sv
// Vending machine credit front end: coin intake, inventory, change launch
// and dispense tracking for the downstream change maker.
module vm_credit_controller #(
  parameter int WIDTH      = 12,
  parameter int MAX_CREDIT = 1000,
  parameter int INV_W      = 8,
  parameter int INIT_INV   = 10,
  parameter int STALL_CYC  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             coin_dollar,
  input  logic             coin_half_dollar,
  input  logic             coin_quarter,
  input  logic             coin_dime,
  input  logic             coin_nickel,
  input  logic [WIDTH-1:0] item_price,
  input  logic             item_select,
  input  logic             cancel,
  input  logic             change_dollar,
  input  logic             change_half_dollar,
  input  logic             change_quarter,
  input  logic             change_dime,
  input  logic             change_nickel,
  input  logic [WIDTH-1:0] local_change,
  output logic [WIDTH-1:0] change,
  output logic             flag_once,
  output logic             flag_dollar,
  output logic             flag_half_dollar,
  output logic             flag_quarter,
  output logic             flag_dime,
  output logic             flag_nickel,
  output logic [WIDTH-1:0] credit,
  output logic             vend,
  output logic             busy,
  output logic             coin_reject,
  output logic             change_short
);

  localparam int SW = $clog2(STALL_CYC + 1);
  localparam logic [WIDTH:0]   MAX_C  = (WIDTH+1)'(MAX_CREDIT);
  localparam logic [SW-1:0]    S_LAST = SW'(STALL_CYC - 1);
  localparam logic [INV_W-1:0] INV0   = INV_W'(INIT_INV);

  typedef enum logic [2:0] {
    S_IDLE, S_CREDIT, S_START, S_DISP, S_DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] credit_q;
  logic [WIDTH-1:0] change_q;
  logic [INV_W-1:0] inv_q [5];
  logic [SW-1:0]    stall_q;
  logic             guard_q;
  logic             once_q;
  logic             vend_q;
  logic             busy_q;
  logic             rej_q;
  logic             short_q;

  logic [4:0]       coin_v;
  logic [4:0]       chg_v;
  logic [4:0]       sat_v;
  logic [WIDTH-1:0] coin_val;
  logic [WIDTH:0]   sum;
  logic             any_coin;
  logic             multi;
  logic             open_st;
  logic             accept;
  logic             reject;
  logic             any_chg;

  // bit 0 = nickel ... bit 4 = dollar, for coins, change pulses and inventory
  assign coin_v = {coin_dollar, coin_half_dollar, coin_quarter,
                   coin_dime, coin_nickel};
  assign chg_v  = {change_dollar, change_half_dollar, change_quarter,
                   change_dime, change_nickel};

  always_comb begin
    coin_val = '0;
    case (coin_v)
      5'b00001: coin_val = WIDTH'(5);
      5'b00010: coin_val = WIDTH'(10);
      5'b00100: coin_val = WIDTH'(25);
      5'b01000: coin_val = WIDTH'(50);
      5'b10000: coin_val = WIDTH'(100);
      default:  coin_val = '0;
    endcase
  end

  always_comb begin
    sat_v = '0;
    for (int i = 0; i < 5; i++) sat_v[i] = (inv_q[i] == '1);
  end

  assign any_coin = |coin_v;
  assign multi    = |(coin_v & (coin_v - 5'd1));
  assign sum      = {1'b0, credit_q} + {1'b0, coin_val};
  assign open_st  = (state_q == S_IDLE) || (state_q == S_CREDIT);
  assign accept   = any_coin && !multi && (sum <= MAX_C)
                    && !(|(coin_v & sat_v))
                    && !item_select && !cancel && open_st;
  assign reject   = any_coin && !accept;
  assign any_chg  = |chg_v;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      change_q <= '0;
      for (int i = 0; i < 5; i++) inv_q[i] <= INV0;
      stall_q  <= '0;
      guard_q  <= 1'b0;
      once_q   <= 1'b0;
      vend_q   <= 1'b0;
      busy_q   <= 1'b0;
      rej_q    <= 1'b0;
      short_q  <= 1'b0;
    end else begin
      once_q  <= 1'b0;
      vend_q  <= 1'b0;
      short_q <= 1'b0;
      rej_q   <= reject;
      if (accept) begin
        credit_q <= sum[WIDTH-1:0];
        for (int i = 0; i < 5; i++)
          if (coin_v[i]) inv_q[i] <= inv_q[i] + 1'b1;
      end
      unique case (state_q)
        S_IDLE: begin
          if (accept) state_q <= S_CREDIT;
        end
        S_CREDIT: begin
          if (cancel) begin
            change_q <= credit_q;
            once_q   <= (credit_q != '0);
            busy_q   <= 1'b1;
            state_q  <= S_START;
          end else if (item_select && credit_q >= item_price) begin
            change_q <= credit_q - item_price;
            once_q   <= (credit_q != item_price);
            vend_q   <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= S_START;
          end
        end
        S_START: begin
          credit_q <= '0;
          guard_q  <= 1'b1;
          stall_q  <= '0;
          state_q  <= (change_q != '0) ? S_DISP : S_DONE;
        end
        S_DISP: begin
          guard_q <= 1'b0;
          for (int i = 0; i < 5; i++)
            if (chg_v[i] && inv_q[i] != '0) inv_q[i] <= inv_q[i] - 1'b1;
          stall_q <= any_chg ? '0 : stall_q + 1'b1;
          if (!any_chg && !guard_q && local_change == '0) begin
            state_q <= S_DONE;
          end else if (!any_chg && stall_q == S_LAST) begin
            // change maker stopped paying out while still owing money
            short_q <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          change_q <= '0;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign change           = change_q;
  assign credit           = credit_q;
  assign flag_once        = once_q;
  assign vend             = vend_q;
  assign busy             = busy_q;
  assign coin_reject      = rej_q;
  assign change_short     = short_q;
  assign flag_nickel      = (inv_q[0] != '0);
  assign flag_dime        = (inv_q[1] != '0);
  assign flag_quarter     = (inv_q[2] != '0);
  assign flag_half_dollar = (inv_q[3] != '0);
  assign flag_dollar      = (inv_q[4] != '0);

endmodule

// File: tb/tb_vm_credit_controller.sv
// Bench for vm_credit_controller: coin tables through a scoreboard queue
// plus hand-written vend, cancel, stall and reset sequences.
module tb_vm_credit_controller;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         reset;
  logic         coin_dollar, coin_half_dollar, coin_quarter;
  logic         coin_dime, coin_nickel;
  logic [W-1:0] item_price;
  logic         item_select, cancel;
  logic         change_dollar, change_half_dollar, change_quarter;
  logic         change_dime, change_nickel;
  logic [W-1:0] local_change;
  logic [W-1:0] change, credit;
  logic         flag_once, flag_dollar, flag_half_dollar, flag_quarter;
  logic         flag_dime, flag_nickel;
  logic         vend, busy, coin_reject, change_short;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [4:0] NK = 5'b00001;
  localparam logic [4:0] DM = 5'b00010;
  localparam logic [4:0] QT = 5'b00100;
  localparam logic [4:0] HD = 5'b01000;
  localparam logic [4:0] DL = 5'b10000;

  typedef struct {
    string      nm;
    logic [4:0] coins;
    int         credit;
    bit         rej;
  } cvec_t;

  cvec_t exp_q[$];
  cvec_t tbl[$];

  always #5 clk = ~clk;

  vm_credit_controller dut (
    .clk(clk), .reset(reset),
    .coin_dollar(coin_dollar), .coin_half_dollar(coin_half_dollar),
    .coin_quarter(coin_quarter), .coin_dime(coin_dime),
    .coin_nickel(coin_nickel),
    .item_price(item_price), .item_select(item_select), .cancel(cancel),
    .change_dollar(change_dollar), .change_half_dollar(change_half_dollar),
    .change_quarter(change_quarter), .change_dime(change_dime),
    .change_nickel(change_nickel), .local_change(local_change),
    .change(change), .flag_once(flag_once),
    .flag_dollar(flag_dollar), .flag_half_dollar(flag_half_dollar),
    .flag_quarter(flag_quarter), .flag_dime(flag_dime),
    .flag_nickel(flag_nickel),
    .credit(credit), .vend(vend), .busy(busy),
    .coin_reject(coin_reject), .change_short(change_short)
  );

  function automatic cvec_t mk(string nm, logic [4:0] c, int cr, bit rj);
    cvec_t v;
    v.nm = nm; v.coins = c; v.credit = cr; v.rej = rj;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_coins(logic [4:0] c);
    {coin_dollar, coin_half_dollar, coin_quarter,
     coin_dime, coin_nickel} = c;
  endtask

  task automatic apply(cvec_t v);
    cvec_t e;
    set_coins(v.coins);
    exp_q.push_back(v);
    tick();
    set_coins(5'b0);
    e = exp_q.pop_front();
    chk({e.nm, "_credit"}, 32'(credit), e.credit);
    chk({e.nm, "_rej"}, 32'(coin_reject), 32'(e.rej));
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) apply(tbl[i]);
    tbl.delete();
  endtask

  task automatic wait_idle(string nm, int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk({nm, "_idle"}, 32'(busy), 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  function automatic logic [4:0] flags();
    return {flag_dollar, flag_half_dollar, flag_quarter,
            flag_dime, flag_nickel};
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1);
  end

  initial begin
    int cyc;
    reset = 1'b0;
    set_coins(5'b0);
    item_price = '0; item_select = 0; cancel = 0;
    {change_dollar, change_half_dollar, change_quarter,
     change_dime, change_nickel} = 5'b0;
    local_change = '0;
    tick();
    chk("rst_credit", 32'(credit), 0);
    chk("rst_change", 32'(change), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pulses", 32'({vend, flag_once, coin_reject, change_short}), 0);
    chk("rst_flags", 32'(flags()), 32'h1f);
    reset = 1'b1;
    tick();

    // vend with change
    tbl.push_back(mk("t1_dime", DM, 10, 0));
    tbl.push_back(mk("t1_quarter", QT, 35, 0));
    tbl.push_back(mk("t1_dollar", DL, 135, 0));
    run_tbl();
    item_price = 110; item_select = 1;
    tick();
    item_select = 0;
    chk("t1_vend", 32'(vend), 1);
    chk("t1_change", 32'(change), 25);
    chk("t1_once", 32'(flag_once), 1);
    chk("t1_busy", 32'(busy), 1);
    local_change = 25;
    tick();
    chk("t1_once_1cyc", 32'(flag_once), 0);
    chk("t1_vend_1cyc", 32'(vend), 0);
    chk("t1_credit_clr", 32'(credit), 0);
    change_quarter = 1;
    tick();
    change_quarter = 0; local_change = 0;
    wait_idle("t1", 6);
    chk("t1_change_clr", 32'(change), 0);

    // cancel refund; coin during dispense is rejected
    tbl.push_back(mk("t2_q1", QT, 25, 0));
    tbl.push_back(mk("t2_q2", QT, 50, 0));
    run_tbl();
    cancel = 1;
    tick();
    cancel = 0;
    chk("t2_vend", 32'(vend), 0);
    chk("t2_change", 32'(change), 50);
    chk("t2_once", 32'(flag_once), 1);
    local_change = 50;
    tick();
    change_half_dollar = 1; coin_nickel = 1;
    tick();
    change_half_dollar = 0; coin_nickel = 0;
    chk("t2_busy_rej", 32'(coin_reject), 1);
    chk("t2_busy_credit", 32'(credit), 0);
    local_change = 0;
    wait_idle("t2", 6);
    chk("t2_flags", 32'(flags()), 32'h1f);

    // credit limit and multi-coin rejection
    for (int i = 0; i < 9; i++)
      tbl.push_back(mk("t3_dl", DL, 100 * (i + 1), 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk("t3_qt", QT, 925 + 25 * i, 0));
    tbl.push_back(mk("t3_nk", NK, 980, 0));
    tbl.push_back(mk("t3_qt_over", QT, 980, 1));
    tbl.push_back(mk("t3_multi", DM | NK, 980, 1));
    tbl.push_back(mk("t3_dm", DM, 990, 0));
    tbl.push_back(mk("t3_nk2", NK, 995, 0));
    tbl.push_back(mk("t3_at_max", NK, 1000, 0));
    tbl.push_back(mk("t3_past_max", NK, 1000, 1));
    run_tbl();
    pulse_reset();
    tick();
    chk("t3_rst_credit", 32'(credit), 0);

    // cancel beats item_select; coin alongside is rejected
    tbl.push_back(mk("t5_q1", QT, 25, 0));
    tbl.push_back(mk("t5_q2", QT, 50, 0));
    tbl.push_back(mk("t5_q3", QT, 75, 0));
    run_tbl();
    item_price = 50; item_select = 1; cancel = 1; coin_nickel = 1;
    tick();
    item_select = 0; cancel = 0; coin_nickel = 0;
    chk("t5_vend", 32'(vend), 0);
    chk("t5_change", 32'(change), 75);
    chk("t5_once", 32'(flag_once), 1);
    chk("t5_rej", 32'(coin_reject), 1);
    chk("t5_credit", 32'(credit), 75);
    local_change = 75;
    tick();
    local_change = 0;
    wait_idle("t5", 6);

    // drain dimes to 0 (one extra pulse checks the floor), nickels to 1
    pulse_reset();
    tick();
    tbl.push_back(mk("t4_dl", DL, 100, 0));
    run_tbl();
    cancel = 1;
    tick();
    cancel = 0;
    chk("t4_prep_change", 32'(change), 100);
    local_change = 100;
    tick();
    for (int i = 0; i < 11; i++) begin
      change_dime = 1;
      tick();
    end
    change_dime = 0;
    chk("t4_dime_floor", 32'(flag_dime), 0);
    for (int i = 0; i < 9; i++) begin
      change_nickel = 1;
      tick();
    end
    change_nickel = 0;
    chk("t4_nickel_left", 32'(flag_nickel), 1);
    local_change = 0;
    wait_idle("t4_prep", 6);

    // stall abort
    tbl.push_back(mk("t4_qt", QT, 25, 0));
    run_tbl();
    item_price = 15; item_select = 1;
    tick();
    item_select = 0;
    chk("t4_vend", 32'(vend), 1);
    chk("t4_change", 32'(change), 10);
    local_change = 10;
    tick();
    change_nickel = 1;
    tick();
    change_nickel = 0;
    chk("t4_nickel_fall", 32'(flag_nickel), 0);
    chk("t4_dime_zero", 32'(flag_dime), 0);
    local_change = 5;
    cyc = 0;
    while (!change_short && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("t4_short_seen", 32'(change_short), 1);
    chk("t4_stall_cycles", 32'(cyc), 16);
    tick();
    chk("t4_short_1cyc", 32'(change_short), 0);
    chk("t4_idle", 32'(busy), 0);
    chk("t4_change_clr", 32'(change), 0);
    local_change = 0;

    // async reset mid-dispense
    tbl.push_back(mk("t6_dl", DL, 100, 0));
    run_tbl();
    cancel = 1;
    tick();
    cancel = 0;
    local_change = 100;
    tick();
    change_dollar = 1;
    tick();
    tick();
    change_dollar = 0;
    chk("t6_mid_busy", 32'(busy), 1);
    reset = 1'b0;
    #2;
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_change", 32'(change), 0);
    chk("t6_rst_credit", 32'(credit), 0);
    chk("t6_rst_flags", 32'(flags()), 32'h1f);
    reset = 1'b1;
    local_change = 0;
    tbl.push_back(mk("t6_after", DM, 10, 0));
    run_tbl();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
